// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 streaming convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'b00,
        MODE_BLUR  = 2'b01,
        MODE_SOBEL = 2'b10,
        MODE_MAG   = 2'b11
    } conv_mode_e;

    localparam int GAUSS_SHIFT = 4;

    // Sobel results span +/-4*(2^w-1), which needs three extra bits including sign.
    function automatic int grad_w(input int pix_w);
        return pix_w + 3;
    endfunction

endpackage

// File: rtl/conv3x3_linebuf.sv
// Two-tap line delay: returns the pixels seen one and two lines earlier at the current column.
module conv3x3_linebuf #(
    parameter int WIDTH_P = 8,
    parameter int DEPTH_P = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [WIDTH_P-1:0] data_i,
    output logic [WIDTH_P-1:0] tap1_o,
    output logic [WIDTH_P-1:0] tap2_o
);

    localparam int PW = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH_P - 1);

    logic [WIDTH_P-1:0] line1_mem [DEPTH_P];
    logic [WIDTH_P-1:0] line2_mem [DEPTH_P];
    logic [PW-1:0]      ptr;

    // One pointer serves as both read and write address; reads see the old contents.
    assign tap1_o = line1_mem[ptr];
    assign tap2_o = line2_mem[ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr <= '0;
        end else if (en_i) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            line1_mem[ptr] <= data_i;
            line2_mem[ptr] <= line1_mem[ptr];
        end
    end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution: pass, Gaussian blur, signed Sobel or saturated gradient magnitude
// over interior pixels of a raster frame, with a single registered output stage.
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int WIDTH_P   = 8,
    parameter int LINE_W_P  = 16,
    parameter int FRAME_H_P = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [WIDTH_P-1:0]        data_i,
    input  logic [1:0]                mode_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [WIDTH_P-1:0]        pix_o,
    output logic signed [WIDTH_P+2:0] gx_o,
    output logic signed [WIDTH_P+2:0] gy_o,
    output logic                      last_o
);

    localparam int GW = grad_w(WIDTH_P);
    localparam int SW = WIDTH_P + GAUSS_SHIFT;
    localparam int CW = (LINE_W_P > 1) ? $clog2(LINE_W_P) : 1;
    localparam int RW = (FRAME_H_P > 1) ? $clog2(FRAME_H_P) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_W_P - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_H_P - 1);
    localparam logic [GW:0]   PIX_MAX  = (GW+1)'((1 << WIDTH_P) - 1);

    function automatic logic [GW-1:0] w121(input logic [WIDTH_P-1:0] a,
                                           input logic [WIDTH_P-1:0] b,
                                           input logic [WIDTH_P-1:0] c);
        return GW'(a) + (GW'(b) << 1) + GW'(c);
    endfunction

    function automatic logic [WIDTH_P-1:0] blur_trunc(input logic [SW-1:0] sum);
        logic [SW-1:0] shifted;
        shifted = sum >> GAUSS_SHIFT;
        return shifted[WIDTH_P-1:0];
    endfunction

    function automatic logic [WIDTH_P-1:0] mag_sat(input logic signed [GW-1:0] gx,
                                                   input logic signed [GW-1:0] gy);
        logic [GW-1:0] ax;
        logic [GW-1:0] ay;
        logic [GW:0]   s;
        ax = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
        ay = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
        s  = {1'b0, ax} + {1'b0, ay};
        return (s > PIX_MAX) ? {WIDTH_P{1'b1}} : s[WIDTH_P-1:0];
    endfunction

    logic                accept;
    logic [CW-1:0]       col;
    logic [RW-1:0]       row;
    conv_mode_e          mode_q;
    logic [WIDTH_P-1:0]  tap1, tap2;
    logic [WIDTH_P-1:0]  win_q [3][3];
    logic [WIDTH_P-1:0]  win_n [3][3];

    logic                vld_p0, last_p0;
    logic [WIDTH_P-1:0]  pix_p0;
    logic signed [GW-1:0] gx_p0, gy_p0, gx_raw, gy_raw;
    logic [SW-1:0]       gsum;

    logic                vld_p1, last_p1;
    logic [WIDTH_P-1:0]  pix_p1;
    logic signed [GW-1:0] gx_p1, gy_p1;

    assign ready_o = !valid_o | ready_i;
    assign accept  = valid_i & ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col    <= '0;
            row    <= '0;
            mode_q <= MODE_PASS;
        end else if (accept) begin
            if (col == '0 && row == '0) mode_q <= conv_mode_e'(mode_i);
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    conv3x3_linebuf #(
        .WIDTH_P (WIDTH_P),
        .DEPTH_P (LINE_W_P)
    ) u_linebuf (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (accept),
        .data_i (data_i),
        .tap1_o (tap1),
        .tap2_o (tap2)
    );

    // Row 0 is two lines back, row 2 the current line; column 2 is the newest pixel.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_n[r][0] = win_q[r][1];
            win_n[r][1] = win_q[r][2];
        end
        win_n[0][2] = tap2;
        win_n[1][2] = tap1;
        win_n[2][2] = data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_q[r][c] <= '0;
        end else if (accept) begin
            win_q <= win_n;
        end
    end

    // Stage p0: kernel arithmetic on the window as it stands after this accept.
    always_comb begin
        gx_raw = $signed(w121(win_n[0][2], win_n[1][2], win_n[2][2]))
               - $signed(w121(win_n[0][0], win_n[1][0], win_n[2][0]));
        gy_raw = $signed(w121(win_n[2][0], win_n[2][1], win_n[2][2]))
               - $signed(w121(win_n[0][0], win_n[0][1], win_n[0][2]));
        gsum   = SW'(w121(win_n[0][0], win_n[0][1], win_n[0][2]))
               + (SW'(w121(win_n[1][0], win_n[1][1], win_n[1][2])) << 1)
               + SW'(w121(win_n[2][0], win_n[2][1], win_n[2][2]));
        vld_p0  = accept && (col >= CW'(2)) && (row >= RW'(2));
        last_p0 = (col == COL_LAST) && (row == ROW_LAST);
        pix_p0  = '0;
        gx_p0   = '0;
        gy_p0   = '0;
        case (mode_q)
            MODE_PASS:  pix_p0 = win_n[1][1];
            MODE_BLUR:  pix_p0 = blur_trunc(gsum);
            MODE_SOBEL: begin
                gx_p0 = gx_raw;
                gy_p0 = gy_raw;
            end
            MODE_MAG: begin
                pix_p0 = mag_sat(gx_raw, gy_raw);
                gx_p0  = gx_raw;
                gy_p0  = gy_raw;
            end
            default: pix_p0 = '0;
        endcase
    end

    // Stage p1: output register, held while downstream stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            pix_p1  <= '0;
            gx_p1   <= '0;
            gy_p1   <= '0;
        end else if (vld_p0) begin
            vld_p1  <= 1'b1;
            last_p1 <= last_p0;
            pix_p1  <= pix_p0;
            gx_p1   <= gx_p0;
            gy_p1   <= gy_p0;
        end else if (ready_i) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end
    end

    assign valid_o = vld_p1;
    assign last_o  = last_p1;
    assign pix_o   = pix_p1;
    assign gx_o    = gx_p1;
    assign gy_o    = gy_p1;

endmodule

// File: doc/conv3x3_stream.md
Name: conv3x3_stream

Overview:
- Parametrised 3x3 streaming convolution engine; successor to the fixed-function line-buffered box/Gaussian stage in the image pipeline.
- Accepts a raster pixel stream with valid/ready and keeps two line buffers plus a 3x3 window.
- Emits one result per interior pixel in one of four runtime-selectable modes: pass-through, Gaussian blur, signed Sobel gradients, or saturated gradient magnitude.
- Tracks frame position itself, drops border pixels, and marks the last output of each frame.

Parameters:
- WIDTH_P, 8, unsigned pixel width in bits.
- LINE_W_P, 16, pixels per line (>=3).
- FRAME_H_P, 16, lines per frame (>=3).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- valid_i  in  1  input pixel valid.
- ready_o  out  1  block can accept a pixel.
- data_i  in  WIDTH_P  input pixel, raster order.
- mode_i  in  2  operation mode, sampled at frame start.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream ready.
- pix_o  out  WIDTH_P  unsigned result: pass, blur or magnitude.
- gx_o  out  WIDTH_P+3  signed horizontal Sobel result.
- gy_o  out  WIDTH_P+3  signed vertical Sobel result.
- last_o  out  1  result is the final pixel of the frame.

Behaviour:
- Handshake:
  - An input is accepted when valid_i & ready_o.
  - ready_o = !valid_o | ready_i. This is a single output register with no bubble when downstream is ready.
- Counters:
  - col (0..LINE_W_P-1) and row (0..FRAME_H_P-1) advance only on accept.
  - col wraps to 0 and increments row. When row wraps, the next frame begins.
- Mode latch:
  - mode_i is captured into mode_q on the accept with col==0 and row==0.
  - Changes to mode_i mid-frame are ignored.
- Line buffers and window:
  - The two line buffers advance only on accept; they supply the pixels from 1 and 2 lines earlier at the same column.
  - The window shifts left on accept. Column 2 loads {line-2, line-1, data_i}.
- Output generation:
  - An accept with col>=2 and row>=2 produces a result for centre (col-1, row-1).
  - The result is registered: valid_o rises the cycle after that accept.
  - All other accepts update state but produce no output. Each frame therefore yields (LINE_W_P-2)*(FRAME_H_P-2) results.
  - The window's first two columns at col 0/1 hold the previous line's tail; those accepts produce no output, so this is harmless.
- Modes:
  - 00 pass: pix_o = centre pixel.
  - 01 Gaussian: pix_o = (sum of kernel [1 2 1;2 4 2;1 2 1] over the window) >> 4. Sum width is WIDTH_P+4; no rounding.
  - 10 Sobel: gx = right column minus left column, weights 1,2,1. gy = bottom row minus top row, weights 1,2,1. Signed WIDTH_P+3 bits; range ±4*(2^WIDTH_P-1). pix_o = 0.
  - 11 magnitude: pix_o = min(|gx|+|gy|, 2^WIDTH_P-1).
  - gx_o/gy_o are driven in modes 10 and 11 and are 0 in modes 00 and 01.
- last_o: asserted with the result produced by the accept at col==LINE_W_P-1, row==FRAME_H_P-1.
- Output hold: while valid_o & !ready_i, all outputs hold stable and no input is accepted.
- Reset:
  - valid_o, last_o, pix_o, gx_o, gy_o = 0; col = row = 0; mode_q = 00; window = 0.
  - Line-buffer contents need not be cleared; they are never used before being rewritten.
  - Reset mid-frame aborts the frame; the next accepted pixel is (0,0).
- Simultaneous events: output drain and new result in the same cycle are legal (ready_i=1 with an output-producing accept).

Decomposition:
- conv_pkg:
  - conv_mode_e typedef (MODE_PASS, MODE_BLUR, MODE_SOBEL, MODE_MAG).
  - Gaussian shift constant 4.
  - Function returning the gradient width (WIDTH_P+3).
- One sub-module, conv3x3_linebuf:
  - Two-tap line delay of depth LINE_W_P, advancing on an enable input.
  - Implemented as RAM plus read/write pointer.

Test Plan:
- LINE_W_P=4, FRAME_H_P=4, constant 100, mode 01 -> exactly 4 results, pix_o=100, last_o on the 4th.
- Horizontal ramp pixel=10*col, mode 10 -> every result gx_o=+80, gy_o=0.
- Vertical step (rows 0-1 = 0, rows 2-3 = 255), mode 11 -> gy=1020, pix_o saturates to 255.
- mode_i toggled 01->10 mid-frame -> whole frame stays Gaussian; the next frame uses Sobel.
- Random ready_i (30% low) with continuous valid_i -> outputs match the golden model, none dropped or duplicated, outputs stable while stalled.
- rst_i asserted after 7 pixels, then a clean frame -> valid_o=0 the cycle after reset, and the new frame produces the correct 4 results.
